// File: rtl/max6675_emulator.sv
// max6675_emulator: read-only SPI slave that answers a 16-bit MAX6675 read
// with {1'b0, temp[11:0], open_flag, 1'b0, 1'b0}, MSB first, updated on sclk
// falling edges. A free-running conversion timer latches temp_in/open_tc.
// Optional feature macro: MAX6675_EMU_OE_EN adds miso_oe and tri-states miso
// whenever the output is not enabled.
module max6675_emulator #(
    parameter int CONV_CYCLES = 11_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    output logic        miso,
    input  logic [11:0] temp_in,
    input  logic        open_tc,
    output logic        busy,
`ifdef MAX6675_EMU_OE_EN
    output logic        miso_oe,
`endif
    output logic        frame_done
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CONV_RELOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_CS_HIGH = 2'd0,
        IDLE         = 2'd1,
        SHIFT        = 2'd2
    } state_t;

    // Synchronizers start low so a cs held low through reset is never seen
    // as high; the FSM waits for a genuine high level before arming.
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic                   cs_prev_r;
    logic                   sclk_prev_r;
    logic                   cs_sync_s;
    logic                   sclk_sync_s;
    logic                   cs_rise_s;
    logic                   cs_fall_s;
    logic                   sclk_fall_s;

    state_t          state_r, state_s;
    logic [15:0]     shift_r, shift_s;
    logic [4:0]      bit_cnt_r, bit_cnt_s;
    logic            miso_r, miso_s;
    logic            frame_done_r, frame_done_s;
    logic [CNT_W-1:0] cnt_r;
    logic            busy_r;
    logic [12:0]     result_r;          // {temp[11:0], open}
    logic [15:0]     frame_word_s;

    assign cs_sync_s    = cs_sync_r[SYNC_STAGES-1];
    assign sclk_sync_s  = sclk_sync_r[SYNC_STAGES-1];
    assign cs_rise_s    = cs_sync_s & ~cs_prev_r;
    assign cs_fall_s    = ~cs_sync_s & cs_prev_r;
    assign sclk_fall_s  = ~sclk_sync_s & sclk_prev_r;
    assign frame_word_s = {1'b0, result_r, 2'b00};

    // Bring cs/sclk into the clk domain and keep one delayed copy for edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_prev_r   <= 1'b0;
            sclk_prev_r <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            cs_prev_r   <= cs_sync_s;
            sclk_prev_r <= sclk_sync_s;
        end
    end

    // Conversion timer: runs while busy with cs high, reloads on every cs rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= CONV_RELOAD;
            busy_r   <= 1'b1;
            result_r <= 13'h0000;
        end else if (cs_rise_s) begin
            cnt_r  <= CONV_RELOAD;
            busy_r <= 1'b1;
        end else if (cs_fall_s) begin
            busy_r <= 1'b0;             // a read aborts any running conversion
        end else if (busy_r && cs_sync_s) begin
            if (cnt_r == CNT_ZERO) begin
                result_r <= {temp_in, open_tc};
                busy_r   <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    // Frame FSM next-state and serializer outputs
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        miso_s       = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            WAIT_CS_HIGH: begin
                if (cs_sync_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_CS_HIGH;
                end
            end
            IDLE: begin
                if (cs_fall_s) begin
                    shift_s   = frame_word_s;
                    bit_cnt_s = 5'd0;
                    miso_s    = frame_word_s[15];
                    state_s   = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cs_rise_s) begin
                    frame_done_s = 1'b1;
                    state_s      = IDLE;
                end else if (sclk_fall_s && (bit_cnt_r < 5'd16)) begin
                    shift_s   = {shift_r[14:0], 1'b0};
                    bit_cnt_s = bit_cnt_r + 5'd1;
                    miso_s    = (bit_cnt_r == 5'd15) ? 1'b0 : shift_r[14];
                end else if (sclk_fall_s) begin
                    miso_s = 1'b0;      // past the 16th bit the line stays low
                end else begin
                    miso_s = miso_r;
                end
            end
            default: begin
                state_s = WAIT_CS_HIGH;
            end
        endcase
    end

    // Frame FSM state and registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= WAIT_CS_HIGH;
            shift_r      <= 16'h0000;
            bit_cnt_r    <= 5'd0;
            miso_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            miso_r       <= miso_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign busy       = busy_r;
    assign frame_done = frame_done_r;

`ifdef MAX6675_EMU_OE_EN
    logic oe_r, oe_s;

    // Output enable: asserted from the frame load until cs is seen high
    always_comb begin
        oe_s = 1'b0;
        if (state_r == IDLE) begin
            oe_s = cs_fall_s;
        end else if (state_r == SHIFT) begin
            oe_s = ~cs_sync_s;
        end else begin
            oe_s = 1'b0;
        end
    end

    // Output-enable register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_r <= 1'b0;
        end else begin
            oe_r <= oe_s;
        end
    end

    assign miso_oe = oe_r;
    assign miso    = oe_r ? miso_r : 1'bz;
`else
    assign miso = miso_r;
`endif

endmodule
